// File: rtl/lpgbt_rs_pkg.sv
// GF(8) arithmetic and RS(7,5) geometry shared by the lpGBT downlink decoder.
// Latency: n/a (types, constants and combinational helper functions only).
// Backpressure: n/a.
//
// Field x^3+x+1 with alpha = 2. Power table: a^0..a^6 = 1,2,4,3,6,7,5.
package lpgbt_rs_pkg;

    localparam int SYM_W  = 3;
    localparam int CW_LEN = 7;
    localparam int CW_W   = SYM_W * CW_LEN;

    localparam logic [3:0] GF8_POLY  = 4'b1011;
    localparam logic [2:0] GF8_ALPHA = 3'd2;

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [CW_W-1:0]  cw_t;

    // Carry-less multiply, then fold bits 4 and 3 back with the field polynomial.
    function automatic sym_t gf8_mul(input sym_t a, input sym_t b);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) p = p ^ ({2'b00, a} << i);
        end
        if (p[4]) p = p ^ ({1'b0, GF8_POLY} << 1);
        if (p[3]) p = p ^ {1'b0, GF8_POLY};
        return p[2:0];
    endfunction

    // alpha^e for e in 0..6; e = 7 aliases to alpha^0.
    function automatic sym_t gf8_antilog(input logic [2:0] e);
        sym_t r;
        case (e)
            3'd0:    r = 3'd1;
            3'd1:    r = 3'd2;
            3'd2:    r = 3'd4;
            3'd3:    r = 3'd3;
            3'd4:    r = 3'd6;
            3'd5:    r = 3'd7;
            3'd6:    r = 3'd5;
            default: r = 3'd1;
        endcase
        return r;
    endfunction

    // (a - b) mod 7 for operands already in 0..6.
    function automatic logic [2:0] sub7(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + 4'd7;
        return d[2:0];
    endfunction

endpackage

// File: rtl/rs_7_5_decoder_pipe_if.sv
// Codeword stream in, corrected codeword plus status out, valid/ready on both sides.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the sink, in_ready toward the source.
//
// Ports: in_valid/in_ready/in_data (21b), out_valid/out_ready/out_data (21b),
//        out_corrected, out_uncorr, out_err_pos (3b).
//        slave = decoder view, master = source/sink view.
interface rs_7_5_decoder_pipe_if;
    import lpgbt_rs_pkg::*;

    logic  in_valid;
    logic  in_ready;
    cw_t   in_data;
    logic  out_valid;
    logic  out_ready;
    cw_t   out_data;
    logic  out_corrected;
    logic  out_uncorr;
    sym_t  out_err_pos;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_corrected, out_uncorr, out_err_pos
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_corrected, out_uncorr, out_err_pos
    );
endinterface

// File: rtl/gf8_log.sv
// Discrete log in GF(8) (alpha = 2); err marks a zero operand, which has no log.
// Latency: 0 (combinational).
// Backpressure: none.
//
// Ports: a (3b) -> res (3b, 0..6), err (1 when a == 0, res forced to 0).
module gf8_log
    import lpgbt_rs_pkg::*;
(
    input  sym_t a,
    output sym_t res,
    output logic err
);

    always_comb begin
        err = (a == '0);
        case (a)
            3'd1:    res = 3'd0;
            3'd2:    res = 3'd1;
            3'd4:    res = 3'd2;
            3'd3:    res = 3'd3;
            3'd6:    res = 3'd4;
            3'd7:    res = 3'd5;
            3'd5:    res = 3'd6;
            default: res = 3'd0;
        endcase
    end

endmodule

// File: rtl/rs_7_5_syndrome.sv
// Syndromes S1 = r(alpha), S2 = r(alpha^2) of a 21-bit RS(7,5) received word.
// Latency: 0 (combinational).
// Backpressure: none.
//
// Ports: cw (21b received word, symbol i at [3i+2:3i]) -> s1, s2 (3b each).
module rs_7_5_syndrome
    import lpgbt_rs_pkg::*;
(
    input  cw_t  cw,
    output sym_t s1,
    output sym_t s2
);

    always_comb begin
        s1 = '0;
        s2 = '0;
        for (int i = 0; i < CW_LEN; i++) begin
            s1 = s1 ^ gf8_mul(cw[SYM_W*i +: SYM_W], gf8_antilog(3'(i)));
            s2 = s2 ^ gf8_mul(cw[SYM_W*i +: SYM_W], gf8_antilog(3'((2 * i) % 7)));
        end
    end

endmodule

// File: rtl/rs_7_5_decoder_pipe.sv
// RS(7,5) GF(8) single-symbol corrector: syndrome -> log -> correct, with event counters.
// Latency: 3 cycles from input handshake to out_valid when not stalled.
// Backpressure: whole pipe freezes while out_valid & !out_ready; in_ready mirrors that.
//
// Ports: clk, rst_n (sync, active low); bus (slave modport: in_*/out_* stream);
//        cnt_clr (sync clear); cnt_corrected, cnt_uncorr (CNT_W, saturating).
module rs_7_5_decoder_pipe
    import lpgbt_rs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rs_7_5_decoder_pipe_if.slave  bus,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_corrected,
    output logic [CNT_W-1:0]      cnt_uncorr
);

    logic adv;
    assign adv        = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;

    // Stage A: syndromes
    sym_t syn_s1, syn_s2;
    logic a_vld;
    cw_t  a_data;
    sym_t a_s1, a_s2;

    rs_7_5_syndrome u_syn (
        .cw (bus.in_data),
        .s1 (syn_s1),
        .s2 (syn_s2)
    );

    // Stage B: logs and zero flags
    sym_t l1, l2;
    logic z1, z2;
    logic b_vld;
    cw_t  b_data;
    sym_t b_l1, b_l2;
    logic b_z1, b_z2;

    gf8_log u_log1 (.a(a_s1), .res(l1), .err(z1));
    gf8_log u_log2 (.a(a_s2), .res(l2), .err(z2));

    // Stage C decision. For a single error e at position p: L1 = log e + p,
    // L2 = log e + 2p, so p = L2 - L1 and log e = L1 - p (all mod 7).
    sym_t c_p, c_v, c_pos;
    cw_t  c_data;
    logic c_corr, c_unc;

    always_comb begin
        c_p    = sub7(b_l2, b_l1);
        c_v    = gf8_antilog(sub7(b_l1, c_p));
        c_data = b_data;
        c_corr = 1'b0;
        c_unc  = 1'b0;
        c_pos  = '0;
        if (!b_z1 && !b_z2) begin
            c_data = b_data ^ (cw_t'(c_v) << (SYM_W * c_p));
            c_corr = 1'b1;
            c_pos  = c_p;
        end else if (b_z1 != b_z2) begin
            c_unc  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_vld             <= 1'b0;
            a_data            <= '0;
            a_s1              <= '0;
            a_s2              <= '0;
            b_vld             <= 1'b0;
            b_data            <= '0;
            b_l1              <= '0;
            b_l2              <= '0;
            b_z1              <= 1'b0;
            b_z2              <= 1'b0;
            bus.out_valid     <= 1'b0;
            bus.out_data      <= '0;
            bus.out_corrected <= 1'b0;
            bus.out_uncorr    <= 1'b0;
            bus.out_err_pos   <= '0;
        end else if (adv) begin
            a_vld  <= bus.in_valid;
            a_data <= bus.in_data;
            a_s1   <= syn_s1;
            a_s2   <= syn_s2;
            b_vld  <= a_vld;
            b_data <= a_data;
            b_l1   <= l1;
            b_l2   <= l2;
            b_z1   <= z1;
            b_z2   <= z2;
            bus.out_valid <= b_vld;
            // Output fields only move on real words so idle outputs keep their last value.
            if (b_vld) begin
                bus.out_data      <= c_data;
                bus.out_corrected <= c_corr;
                bus.out_uncorr    <= c_unc;
                bus.out_err_pos   <= c_pos;
            end
        end
    end

    logic out_hs;
    assign out_hs = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_corrected <= '0;
            cnt_uncorr    <= '0;
        end else begin
            if (out_hs && bus.out_corrected && (cnt_corrected != '1))
                cnt_corrected <= cnt_corrected + CNT_W'(1);
            if (out_hs && bus.out_uncorr && (cnt_uncorr != '1))
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rs_7_5_decoder_pipe.sv
// Directed bench for rs_7_5_decoder_pipe (CNT_W = 2 so saturation is reachable).
// Latency: n/a.
// Backpressure: stalls driven from the bench.
module tb_rs_7_5_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cnt_clr;
    logic [1:0] cnt_corrected;
    logic [1:0] cnt_uncorr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    rs_7_5_decoder_pipe_if bus ();

    rs_7_5_decoder_pipe #(.CNT_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .cnt_clr       (cnt_clr),
        .cnt_corrected (cnt_corrected),
        .cnt_uncorr    (cnt_uncorr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {data, corrected, uncorr, err_pos} packed for one compare.
    function automatic logic [31:0] ev(input logic [20:0] d, input logic c,
                                       input logic u, input logic [2:0] p);
        return {6'd0, d, c, u, p};
    endfunction

    function automatic logic [31:0] outv();
        return {6'd0, bus.out_data, bus.out_corrected, bus.out_uncorr, bus.out_err_pos};
    endfunction

    task automatic send_word(input logic [20:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Starts one negedge after the handshake edge; returns how many cycles
    // it took for out_valid to appear (10 = never).
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_word(input string tag, input logic [20:0] d, input logic [31:0] exp);
        int lat;
        send_word(d);
        wait_out(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_out"}, outv(), exp);
        @(negedge clk);
    endtask

    logic [20:0] sw_data [5] = '{21'h000073, 21'h010073, 21'h140000, 21'h00000C, 21'h003000};
    logic [31:0] sw_exp  [5];
    int          sent, got, stall_cnt, seen, lat;
    logic        prev_stall;
    logic [31:0] held;

    initial begin
        rst_n        = 1'b0;
        cnt_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out", outv(), 32'd0);
        chk("rst_cnt_corr", 32'(cnt_corrected), 32'd0);
        chk("rst_cnt_unc", 32'(cnt_uncorr), 32'd0);

        // Single words, unstalled
        do_word("zero", 21'h000000, ev(21'h0, 1'b0, 1'b0, 3'd0));
        chk("zero_no_dup", 32'(bus.out_valid), 32'd0);
        chk("zero_cnt", 32'(cnt_corrected), 32'd0);
        do_word("sym4", 21'h003000, ev(21'h0, 1'b1, 1'b0, 3'd4));
        chk("sym4_cnt", 32'(cnt_corrected), 32'd1);
        do_word("sym0", 21'h000001, ev(21'h0, 1'b1, 1'b0, 3'd0));
        chk("sym0_cnt", 32'(cnt_corrected), 32'd2);
        do_word("unc", 21'h00000C, ev(21'h00000C, 1'b0, 1'b1, 3'd0));
        chk("unc_cnt", 32'(cnt_uncorr), 32'd1);
        chk("unc_cnt_corr", 32'(cnt_corrected), 32'd2);

        // Back-to-back stream with a 4-cycle output stall
        sw_exp[0] = ev(21'h000073, 1'b0, 1'b0, 3'd0);
        sw_exp[1] = ev(21'h000073, 1'b1, 1'b0, 3'd5);
        sw_exp[2] = ev(21'h000000, 1'b1, 1'b0, 3'd6);
        sw_exp[3] = ev(21'h00000C, 1'b0, 1'b1, 3'd0);
        sw_exp[4] = ev(21'h000000, 1'b1, 1'b0, 3'd4);
        sent = 0; got = 0; stall_cnt = 0; prev_stall = 1'b0; held = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 4 && c < 8);
            bus.in_valid  = (sent < 5);
            if (sent < 5) bus.in_data = sw_data[sent];
            else          bus.in_data = '0;
            #1;
            if (prev_stall) begin
                chk("stall_hold_vld", 32'(bus.out_valid), 32'd1);
                chk("stall_hold_out", outv(), held);
            end
            if (bus.out_valid && !bus.out_ready) begin
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                stall_cnt++;
            end else begin
                chk("flow_in_ready", 32'(bus.in_ready), 32'd1);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = outv();
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("stream_w%0d", got), outv(), sw_exp[got]);
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        chk("stream_got", 32'(got), 32'd5);
        chk("stream_stalls", 32'(stall_cnt), 32'd4);
        @(negedge clk);
        chk("sat_cnt_corr", 32'(cnt_corrected), 32'd3);
        chk("stream_cnt_unc", 32'(cnt_uncorr), 32'd2);

        // Clear coincident with a corrected handshake
        send_word(21'h003000);
        wait_out(lat);
        chk("clr_lat", 32'(lat), 32'd3);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_cnt_corr", 32'(cnt_corrected), 32'd0);
        chk("clr_cnt_unc", 32'(cnt_uncorr), 32'd0);
        do_word("post_clr", 21'h000001, ev(21'h0, 1'b1, 1'b0, 3'd0));
        chk("post_clr_cnt", 32'(cnt_corrected), 32'd1);

        // Reset with two words in flight
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 21'h003000;
        @(negedge clk);
        bus.in_data  = 21'h000001;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(cnt_corrected), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_no_out", 32'(seen), 32'd0);
        chk("mid_rst_out", outv(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
